conc_trace_capture: RTL and testbench

Per-cycle response recorder for the concolic bench harness. The stimulus side replays one opcode per clock into the DUT. This block sits at the other end: it samples the driven stimulus bits and the DUT outputs on every enabled clock, stamps each sample with a cycle number, and buffers the entries in a FIFO. A host or bench reader drains the FIFO through a valid/ready port for path/coverage analysis.

---
 rtl/conc_trace_pkg.sv | 41 ++++
 rtl/conc_trace_fifo.sv | 74 +++++++
 rtl/conc_trace_capture.sv | 132 +++++++++++++
 tb/tb_conc_trace_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conc_trace_pkg.sv
// Shared types and helpers for the concolic trace capture block.
package conc_trace_pkg;

  localparam int SAMPLE_W = 5;

  // Bit positions inside the 5-bit sample word.
  localparam int OBS   = 4;
  localparam int LINE2 = 3;
  localparam int LINE1 = 2;
  localparam int OVF   = 1;
  localparam int OUTP  = 0;

  // Default field widths; the struct below describes the default entry layout.
  localparam int STAMP_W_DEF = 16;
  localparam int RUN_W_DEF   = 3;

  typedef struct packed {
    logic [STAMP_W_DEF-1:0] stamp;
    logic [RUN_W_DEF-1:0]   run;
    logic [SAMPLE_W-1:0]    sample;
  } trace_entry_t;

  // Assemble the sample word from the five observed lines.
  function automatic logic [SAMPLE_W-1:0] pack_sample(
    input logic obs,
    input logic line2,
    input logic line1,
    input logic ovf,
    input logic outp
  );
    logic [SAMPLE_W-1:0] s;
    s        = {SAMPLE_W{1'b0}};
    s[OBS]   = obs;
    s[LINE2] = line2;
    s[LINE1] = line1;
    s[OVF]   = ovf;
    s[OUTP]  = outp;
    return s;
  endfunction

endpackage

// File: rtl/conc_trace_fifo.sv
// Synchronous first-word-fall-through FIFO. Push is ignored while full unless
// a pop happens on the same edge; pop is ignored while empty. No drop accounting.
module conc_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && !empty_r;
  assign push_ok_s = push && (!full_r || pop_ok_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and registered status flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (reset && push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Head is shown straight from the array, forced to zero when nothing is held.
  assign pop_data = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count    = count_r;
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/conc_trace_capture.sv
// Per-cycle trace recorder: stamps each enabled sample and buffers it in a FIFO
// drained through a valid/ready port. Define CONC_TRACE_RLE_EN to coalesce
// repeated identical samples into one entry with a run length.
module conc_trace_capture
  import conc_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int RUN_W   = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cap_en,
  input  logic                         line1,
  input  logic                         line2,
  input  logic                         __obs,
  input  logic                         outp,
  input  logic                         overflw,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [STAMP_W+RUN_W+4:0]     rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [15:0]                  dropped
);

  localparam int ENTRY_W = STAMP_W + RUN_W + SAMPLE_W;

  logic [SAMPLE_W-1:0] sample_s;
  logic [STAMP_W-1:0]  stamp_r;
  logic                push_s;
  logic [ENTRY_W-1:0]  push_data_s;
  logic                pop_s;
  logic                drop_s;
  logic [15:0]         dropped_r;
  logic                full_s;
  logic                empty_s;

  assign sample_s = pack_sample(__obs, line2, line1, overflw, outp);

  // Free-running cycle stamp; a capture uses the value before this edge's increment.
  always_ff @(posedge clock) begin
    if (!reset) stamp_r <= {STAMP_W{1'b0}};
    else        stamp_r <= stamp_r + STAMP_W'(1);
  end

`ifdef CONC_TRACE_RLE_EN
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  logic                pend_valid_r;
  logic [STAMP_W-1:0]  pend_stamp_r;
  logic [RUN_W-1:0]    pend_run_r;
  logic [SAMPLE_W-1:0] pend_sample_r;

  // Emit the pending run when it is broken, saturated, or capture stops.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = {pend_stamp_r, pend_run_r, pend_sample_r};
    if (cap_en && pend_valid_r &&
        ((sample_s != pend_sample_r) || (pend_run_r == RUN_MAX))) begin
      push_s = 1'b1;
    end else if (!cap_en && pend_valid_r) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Pending run register: start, extend, restart after emission, or retire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_valid_r  <= 1'b0;
      pend_stamp_r  <= {STAMP_W{1'b0}};
      pend_run_r    <= {RUN_W{1'b0}};
      pend_sample_r <= {SAMPLE_W{1'b0}};
    end else if (cap_en) begin
      if (!pend_valid_r || push_s) begin
        pend_valid_r  <= 1'b1;
        pend_stamp_r  <= stamp_r;
        pend_run_r    <= {RUN_W{1'b0}};
        pend_sample_r <= sample_s;
      end else begin
        pend_run_r    <= pend_run_r + RUN_W'(1);
      end
    end else begin
      pend_valid_r <= 1'b0;
    end
  end
`else
  // Every enabled cycle becomes its own entry with a zero run length.
  always_comb begin
    push_s      = cap_en;
    push_data_s = {stamp_r, {RUN_W{1'b0}}, sample_s};
  end
`endif

  assign pop_s  = rd_valid && rd_ready;
  assign drop_s = push_s && full_s && !pop_s;

  // Count entries lost to a full buffer, sticking at the maximum.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dropped_r <= 16'h0000;
    end else if (drop_s && (dropped_r != 16'hFFFF)) begin
      dropped_r <= dropped_r + 16'h0001;
    end else begin
      dropped_r <= dropped_r;
    end
  end

  conc_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .count     (count),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign rd_valid = !empty_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign dropped  = dropped_r;

endmodule

// File: tb/tb_conc_trace_capture.sv
// Self-checking bench for conc_trace_capture with a queue-based reference model.
module tb_conc_trace_capture;
  import conc_trace_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cap_en = 1'b0;
  logic        line1 = 1'b0;
  logic        line2 = 1'b0;
  logic        obs_s = 1'b0;
  logic        outp = 1'b0;
  logic        overflw = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [23:0] rd_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] dropped;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] exp_q [$];
  logic [15:0] m_stamp = 16'd0;
  int          m_dropped = 0;
  bit          m_pv = 1'b0;
  logic [15:0] m_ps = 16'd0;
  logic [2:0]  m_pr = 3'd0;
  logic [4:0]  m_psm = 5'd0;

  conc_trace_capture #(.DEPTH(16), .STAMP_W(16), .RUN_W(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .cap_en   (cap_en),
    .line1    (line1),
    .line2    (line2),
    .__obs    (obs_s),
    .outp     (outp),
    .overflw  (overflw),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .dropped  (dropped)
  );

  always #5 clock = ~clock;

  // Apply one posedge worth of the specified behaviour to the model.
  task automatic model_edge(input logic rst, input logic en, input logic [4:0] smp, input logic rdy);
    bit          have_push;
    logic [23:0] ent;
    have_push = 1'b0;
    ent = 24'd0;
    if (!rst) begin
      exp_q.delete();
      m_stamp = 16'd0;
      m_dropped = 0;
      m_pv = 1'b0;
    end else begin
`ifdef CONC_TRACE_RLE_EN
      if (en) begin
        if (!m_pv) begin
          m_pv = 1'b1; m_ps = m_stamp; m_pr = 3'd0; m_psm = smp;
        end else if (smp == m_psm && m_pr < 3'd7) begin
          m_pr = m_pr + 3'd1;
        end else begin
          have_push = 1'b1; ent = {m_ps, m_pr, m_psm};
          m_ps = m_stamp; m_pr = 3'd0; m_psm = smp;
        end
      end else if (m_pv) begin
        have_push = 1'b1; ent = {m_ps, m_pr, m_psm};
        m_pv = 1'b0;
      end
`else
      if (en) begin
        have_push = 1'b1; ent = {m_stamp, 3'd0, smp};
      end
`endif
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (have_push) begin
        if (exp_q.size() < 16) exp_q.push_back(ent);
        else if (m_dropped < 65535) m_dropped++;
      end
      m_stamp = m_stamp + 16'd1;
    end
  endtask

  // Drive one cycle, advance the model, and compare all outputs after the edge.
  task automatic cycle(input logic rst, input logic en, input logic [4:0] smp, input logic rdy);
    logic        ev;
    logic [4:0]  ec;
    logic [15:0] ed;
    reset = rst; cap_en = en; rd_ready = rdy;
    {obs_s, line2, line1, overflw, outp} = smp;
    model_edge(rst, en, smp, rdy);
    @(posedge clock); #1;
    ev = (exp_q.size() != 0);
    ec = 5'(exp_q.size());
    ed = 16'(m_dropped);
    checks++;
    if (rd_valid !== ev) begin errors++; $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, ev, $time); end
    checks++;
    if (count !== ec) begin errors++; $display("FAIL count: got %0d expected %0d at %0t", count, ec, $time); end
    checks++;
    if (full !== (ec == 5'd16)) begin errors++; $display("FAIL full: got %b expected %b at %0t", full, (ec == 5'd16), $time); end
    checks++;
    if (empty !== (ec == 5'd0)) begin errors++; $display("FAIL empty: got %b expected %b at %0t", empty, (ec == 5'd0), $time); end
    checks++;
    if (dropped !== ed) begin errors++; $display("FAIL dropped: got %0d expected %0d at %0t", dropped, ed, $time); end
    if (ev) begin
      checks++;
      if (rd_data !== exp_q[0]) begin errors++; $display("FAIL rd_data: got %h expected %h at %0t", rd_data, exp_q[0], $time); end
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || dropped !== 16'd0) begin
      errors++; $display("FAIL reset_state: got v%b e%b f%b c%0d d%0d expected v0 e1 f0 c0 d0", rd_valid, empty, full, count, dropped);
    end
    checks++;
    if ($isunknown(rd_data)) begin errors++; $display("FAIL reset_rd_data: got %h expected known value", rd_data); end
  endtask

  task automatic test_three_samples();
    logic [23:0] exp3 [3];
    exp3[0] = {16'd0, 3'd0, 5'h01};
    exp3[1] = {16'd1, 3'd0, 5'h02};
    exp3[2] = {16'd2, 3'd0, 5'h03};
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'(i + 1), 1'b0);
`ifndef CONC_TRACE_RLE_EN
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL three_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data !== exp3[i]) begin errors++; $display("FAIL three_data%0d: got %h expected %h", i, rd_data, exp3[i]); end
      cycle(1'b1, 1'b0, 5'h00, 1'b1);
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL three_empty: got %b expected 1", empty); end
`else
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 5'h00, 1'b1);
`endif
  endtask

  task automatic test_overflow();
    trace_entry_t head;
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 5'(i), 1'b0);
`ifndef CONC_TRACE_RLE_EN
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || dropped !== 16'd4) begin
      errors++; $display("FAIL overflow_state: got f%b c%0d d%0d expected f1 c16 d4", full, count, dropped);
    end
    for (int i = 0; i < 16; i++) begin
      head = rd_data;
      checks++;
      if (head.stamp !== 16'(i)) begin errors++; $display("FAIL overflow_stamp%0d: got %0d expected %0d", i, head.stamp, i); end
      cycle(1'b1, 1'b0, 5'h00, 1'b1);
    end
`else
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 5'h00, 1'b1);
`endif
  endtask

  task automatic test_back_to_back();
    trace_entry_t head;
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 5'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
`ifndef CONC_TRACE_RLE_EN
      head = rd_data;
      checks++;
      if (head.stamp !== 16'(i)) begin errors++; $display("FAIL b2b_stamp%0d: got %0d expected %0d", i, head.stamp, i); end
`endif
      cycle(1'b1, 1'b1, 5'(i + 16), 1'b1);
`ifndef CONC_TRACE_RLE_EN
      checks++;
      if (count !== 5'd16 || dropped !== 16'd0) begin
        errors++; $display("FAIL b2b_level%0d: got c%0d d%0d expected c16 d0", i, count, dropped);
      end
`endif
    end
  endtask

  task automatic test_rle_split();
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 5'h10, 1'b0);
    cycle(1'b1, 1'b0, 5'h00, 1'b0);
`ifdef CONC_TRACE_RLE_EN
    checks++;
    if (count !== 5'd2) begin errors++; $display("FAIL rle_count: got %0d expected 2", count); end
    checks++;
    if (rd_data !== {16'd0, 3'd7, 5'h10}) begin errors++; $display("FAIL rle_first: got %h expected %h", rd_data, {16'd0, 3'd7, 5'h10}); end
    cycle(1'b1, 1'b0, 5'h00, 1'b1);
    checks++;
    if (rd_data !== {16'd8, 3'd1, 5'h10}) begin errors++; $display("FAIL rle_second: got %h expected %h", rd_data, {16'd8, 3'd1, 5'h10}); end
`endif
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 5'h00, 1'b1);
  endtask

  task automatic test_reset_mid_capture();
    trace_entry_t head;
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 5'(i * 3), 1'b0);
    cycle(1'b0, 1'b1, 5'h1F, 1'b0);
    checks++;
    if (empty !== 1'b1 || count !== 5'd0 || dropped !== 16'd0) begin
      errors++; $display("FAIL midreset_state: got e%b c%0d d%0d expected e1 c0 d0", empty, count, dropped);
    end
    cycle(1'b1, 1'b1, 5'h0A, 1'b0);
    cycle(1'b1, 1'b0, 5'h00, 1'b0);
    head = rd_data;
    checks++;
    if (head.stamp !== 16'd0 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_stamp: got stamp %0d valid %b expected stamp 0 valid 1", head.stamp, rd_valid);
    end
  endtask

  task automatic test_random();
    logic       en;
    logic       rdy;
    logic       rst;
    logic [4:0] smp;
    cycle(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      smp = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
      cycle(rst, en, smp, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_three_samples();
    test_overflow();
    test_back_to_back();
    test_rle_split();
    test_reset_mid_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
